// File: rtl/serv_ibus_prefetch.sv
// ----------------------------------------------------------------------------
// serv_ibus_prefetch
//
// One-entry instruction prefetch buffer between the SERV core fetch port and
// a classic Wishbone instruction master. After every word delivered to the
// core it fetches the next sequential word and parks it in the buffer, so a
// straight-line fetch stream sees a one-cycle hit latency.
//
// Ports
//   clk          core clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_core_adr   fetch address from the core (bits [1:0] ignored)
//   i_core_cyc   fetch request, held by the core until o_core_ack
//   o_core_rdt   instruction word, valid while o_core_ack is high
//   o_core_ack   single-cycle acknowledge to the core
//   i_flush      invalidate the buffer and any outstanding prefetch
//   o_wb_adr     Wishbone address (word aligned)
//   o_wb_cyc     Wishbone cycle/strobe
//   i_wb_rdt     Wishbone read data
//   i_wb_ack     Wishbone acknowledge
// ----------------------------------------------------------------------------
module serv_ibus_prefetch #(
    parameter int WITH_PREFETCH = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_core_adr,
    input  logic        i_core_cyc,
    output logic [31:0] o_core_rdt,
    output logic        o_core_ack,
    input  logic        i_flush,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    localparam bit Pf = (WITH_PREFETCH != 0);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDemand   = 2'd1,
        StPrefetch = 2'd2,
        StDrain    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] buf_q, buf_d;
    logic [29:0] wb_adr_q, wb_adr_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;

    logic [29:0] core_word;
    logic        core_req;
    logic        hit;
    logic        pf_match;
    logic        pf_abort;
    logic        unused_adr;

    assign core_word  = i_core_adr[31:2];
    assign unused_adr = ^i_core_adr[1:0];
    // The core still holds i_core_cyc for the request being acked in the ack
    // cycle; that is not a new request.
    assign core_req   = i_core_cyc & ~ack_q;
    assign hit        = valid_q & ~i_flush & (tag_q == core_word);
    assign pf_match   = (core_word == wb_adr_q);
    // A flush or a jump makes the in-flight prefetch useless.
    assign pf_abort   = i_flush | (core_req & ~pf_match);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        buf_d    = buf_q;
        wb_adr_d = wb_adr_q;
        wb_cyc_d = wb_cyc_q;
        ack_d    = 1'b0;
        rdt_d    = rdt_q;

        if (i_flush) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (core_req) begin
                    valid_d = 1'b0;
                    if (hit) begin
                        ack_d = 1'b1;
                        rdt_d = buf_q;
                        if (Pf) begin
                            state_d  = StPrefetch;
                            wb_adr_d = tag_q + 30'd1;
                        end
                    end else begin
                        state_d  = StDemand;
                        wb_adr_d = core_word;
                        wb_cyc_d = 1'b1;
                    end
                end
            end

            StDemand: begin
                if (wb_cyc_q && i_wb_ack) begin
                    wb_cyc_d = 1'b0;
                    ack_d    = 1'b1;
                    rdt_d    = i_wb_rdt;
                    if (Pf) begin
                        state_d  = StPrefetch;
                        wb_adr_d = wb_adr_q + 30'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StPrefetch: begin
                if (!wb_cyc_q) begin
                    // Prefetch address is set up but not yet on the bus.
                    if (pf_abort) begin
                        state_d = StIdle;
                    end else begin
                        wb_cyc_d = 1'b1;
                    end
                end else if (pf_abort) begin
                    if (i_wb_ack) begin
                        wb_cyc_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (i_wb_ack) begin
                    wb_cyc_d = 1'b0;
                    if (core_req) begin
                        // Core is already waiting for this word: forward it
                        // and chain the next prefetch.
                        ack_d    = 1'b1;
                        rdt_d    = i_wb_rdt;
                        wb_adr_d = wb_adr_q + 30'd1;
                    end else begin
                        buf_d   = i_wb_rdt;
                        tag_d   = wb_adr_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            StDrain: begin
                if (i_wb_ack) begin
                    wb_cyc_d = 1'b0;
                    state_d  = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            buf_q    <= '0;
            wb_adr_q <= '0;
            wb_cyc_q <= 1'b0;
            ack_q    <= 1'b0;
            rdt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            buf_q    <= buf_d;
            wb_adr_q <= wb_adr_d;
            wb_cyc_q <= wb_cyc_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
        end
    end

    assign o_wb_adr   = {wb_adr_q, 2'b00};
    assign o_wb_cyc   = wb_cyc_q;
    assign o_core_rdt = rdt_q;
    // Never acknowledge a request the core is no longer making.
    assign o_core_ack = ack_q & i_core_cyc;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// ----------------------------------------------------------------------------
// tb_serv_ibus_prefetch
//
// Self-checking bench for serv_ibus_prefetch: a Wishbone slave model with
// programmable latency, a scoreboard of expected instruction words pushed at
// request time and popped on o_core_ack, and one task per scenario.
// ----------------------------------------------------------------------------
module tb_serv_ibus_prefetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] core_adr;
    logic        core_cyc;
    logic [31:0] core_rdt;
    logic        core_ack;
    logic        flush;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    logic        slave_ack;
    logic [31:0] slave_rdt;
    logic        late_ack;
    int          wb_lat;
    int          slave_cnt;

    logic [31:0] sb[$];
    logic [31:0] wb_log[$];
    int          ack_count;

    int n_checks;
    int n_pass;

    serv_ibus_prefetch #(.WITH_PREFETCH(1)) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_core_adr (core_adr),
        .i_core_cyc (core_cyc),
        .o_core_rdt (core_rdt),
        .o_core_ack (core_ack),
        .i_flush    (flush),
        .o_wb_adr   (wb_adr),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack)
    );

    assign wb_ack = slave_ack | late_ack;
    assign wb_rdt = late_ack ? 32'hBAD0_BAD0 : slave_rdt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Wishbone slave: acks wb_lat negedges after the cycle is seen.
    always @(negedge clk) begin
        if (wb_cyc && !slave_ack) begin
            slave_cnt = slave_cnt + 1;
            if (slave_cnt >= wb_lat) begin
                slave_ack = 1'b1;
                slave_rdt = mem_word(wb_adr);
                wb_log.push_back(wb_adr);
                slave_cnt = 0;
            end
        end else begin
            slave_ack = 1'b0;
            slave_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (core_ack === 1'b1) ack_count++;
    end

    task automatic fetch(input logic [31:0] adr, input int exp_lat, input string name);
        int          cyc_n;
        logic        got;
        logic [31:0] exp;
        @(posedge clk); #1;
        core_adr = adr;
        core_cyc = 1'b1;
        sb.push_back(mem_word(adr));
        got   = 1'b0;
        cyc_n = 0;
        while (!got && cyc_n < 100) begin
            @(posedge clk); #1;
            cyc_n++;
            if (core_ack === 1'b1) got = 1'b1;
        end
        exp = sb.pop_front();
        n_checks++;
        if (!got) $display("FAIL %s_rdt: no o_core_ack within %0d cycles", name, cyc_n);
        else if (core_rdt !== exp)
            $display("FAIL %s_rdt: got %h expected %h", name, core_rdt, exp);
        else n_pass++;
        if (exp_lat > 0) begin
            n_checks++;
            if (cyc_n !== exp_lat)
                $display("FAIL %s_lat: got %0d expected %0d", name, cyc_n, exp_lat);
            else n_pass++;
        end
        @(posedge clk); #1;
        core_cyc = 1'b0;
    endtask

    task automatic wait_issue(input logic [31:0] exp_adr, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wb_cyc === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen) $display("FAIL %s_issue: o_wb_cyc never rose, expected adr %h", name, exp_adr);
        else if (wb_adr !== exp_adr)
            $display("FAIL %s_issue: o_wb_adr %h expected %h", name, wb_adr, exp_adr);
        else n_pass++;
    endtask

    task automatic wait_quiet(input string name);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 200; i++) begin
            if (wb_cyc === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if (quiet < 3) $display("FAIL %s_quiet: bus still busy, quiet=%0d expected 3", name, quiet);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (wb_cyc !== 1'b0) $display("FAIL rst_wb_cyc: got %b expected 0", wb_cyc); else n_pass++;
        n_checks++;
        if (core_ack !== 1'b0) $display("FAIL rst_ack: got %b expected 0", core_ack); else n_pass++;
        n_checks++;
        if (wb_adr !== 32'h0) $display("FAIL rst_wb_adr: got %h expected 0", wb_adr); else n_pass++;
        n_checks++;
        if (core_rdt !== 32'h0) $display("FAIL rst_rdt: got %h expected 0", core_rdt); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        wb_lat = 3;
        fetch(32'h0000_0100, 4, "cold");
        wait_issue(32'h0000_0104, "cold_pf");
        wait_quiet("cold");
    endtask

    task automatic test_seq_hit();
        int base;
        int n104;
        wb_lat = 6;
        base = wb_log.size();
        fetch(32'h0000_0104, 1, "hit");
        n104 = 0;
        for (int i = base; i < wb_log.size(); i++)
            if (wb_log[i] == 32'h0000_0104) n104++;
        n_checks++;
        if (n104 !== 0) $display("FAIL hit_nobus: %0d bus cycles at 0x104, expected 0", n104);
        else n_pass++;
        wait_issue(32'h0000_0108, "hit_pf");
    endtask

    task automatic test_jump();
        int          base;
        int          acks0;
        logic [31:0] e0;
        logic [31:0] e1;
        base  = wb_log.size();
        acks0 = ack_count;
        fetch(32'h0000_0200, 0, "jump");
        e0 = (wb_log.size() > base)     ? wb_log[base]     : 32'hFFFF_FFFF;
        e1 = (wb_log.size() > base + 1) ? wb_log[base + 1] : 32'hFFFF_FFFF;
        n_checks++;
        if (e0 !== 32'h0000_0108) $display("FAIL jump_drain: bus adr %h expected 00000108", e0);
        else n_pass++;
        n_checks++;
        if (e1 !== 32'h0000_0200) $display("FAIL jump_demand: bus adr %h expected 00000200", e1);
        else n_pass++;
        n_checks++;
        if (ack_count - acks0 !== 1)
            $display("FAIL jump_acks: got %0d acks expected 1", ack_count - acks0);
        else n_pass++;
        wb_lat = 2;
        wait_quiet("jump");
    endtask

    task automatic test_wrap();
        fetch(32'hFFFF_FFFC, 3, "wrap_miss");
        wait_issue(32'h0000_0000, "wrap_pf");
        wait_quiet("wrap");
        fetch(32'h0000_0000, 1, "wrap_hit");
        wait_quiet("wrap_hit");
    endtask

    task automatic test_flush();
        logic [31:0] last;
        fetch(32'h0000_0100, 3, "fl_fill");
        wait_quiet("fl_fill");
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        fetch(32'h0000_0104, 3, "fl_miss");
        last = (wb_log.size() > 0) ? wb_log[wb_log.size() - 1] : 32'hFFFF_FFFF;
        n_checks++;
        if (last !== 32'h0000_0104) $display("FAIL fl_bus: last bus adr %h expected 00000104", last);
        else n_pass++;
        wait_quiet("fl");
    endtask

    task automatic test_reset_mid();
        int acks0;
        wb_lat = 8;
        @(posedge clk); #1;
        core_adr = 32'h0000_0300;
        core_cyc = 1'b1;
        wait_issue(32'h0000_0300, "rm");
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (wb_cyc !== 1'b0) $display("FAIL rm_cyc: got %b expected 0", wb_cyc); else n_pass++;
        n_checks++;
        if (core_ack !== 1'b0) $display("FAIL rm_ack: got %b expected 0", core_ack); else n_pass++;
        n_checks++;
        if (wb_adr !== 32'h0) $display("FAIL rm_adr: got %h expected 0", wb_adr); else n_pass++;
        core_cyc = 1'b0;
        acks0 = ack_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1 late_ack = 1'b1;
        @(negedge clk); #1 late_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (ack_count !== acks0)
            $display("FAIL rm_late: got %0d acks expected %0d", ack_count, acks0);
        else n_pass++;
        n_checks++;
        if (wb_cyc !== 1'b0) $display("FAIL rm_idle: o_wb_cyc %b expected 0", wb_cyc); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        ack_count = 0;
        core_adr  = 32'h0;
        core_cyc  = 1'b0;
        flush     = 1'b0;
        late_ack  = 1'b0;
        slave_ack = 1'b0;
        slave_rdt = 32'h0;
        slave_cnt = 0;
        wb_lat    = 3;
        test_reset();
        test_cold_miss();
        test_seq_hit();
        test_jump();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serv_ibus_prefetch.md
SERV_IBUS_PREFETCH -- requirements
Module: serv_ibus_prefetch

Interface
REQ-001 SHALL have parameter WITH_PREFETCH, default 1, meaning 1 = fetch next sequential word after each demand fetch, 0 = pass-through only.
REQ-002 SHALL have port clk  input  1  core clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_core_adr  input  32  instruction address from the PC shift register.
REQ-005 SHALL have port i_core_cyc  input  1  core fetch request, held until o_core_ack.
REQ-006 SHALL have port o_core_rdt  output  32  instruction word to the core.
REQ-007 SHALL have port o_core_ack  output  1  single-cycle pulse, o_core_rdt valid.
REQ-008 SHALL have port i_flush  input  1  invalidate buffer (fence.i, trap).
REQ-009 SHALL have ports o_wb_adr (output, 32), o_wb_cyc (output, 1), i_wb_rdt (input, 32), i_wb_ack (input, 1): classic Wishbone instruction master.

Function
REQ-010 SHALL hold one buffer entry: 32-bit data, 30-bit tag (word address), valid bit.
REQ-011 SHALL ignore i_core_adr[1:0] for matching; o_wb_adr[1:0] SHALL always be 0.
REQ-012 SHALL implement states IDLE, DEMAND, PREFETCH, DRAIN.
REQ-013 IDLE, i_core_cyc=1, valid=1, tag==i_core_adr[31:2]: o_core_ack=1 and o_core_rdt=buffer data in the next cycle; valid cleared; go PREFETCH at tag+1 if WITH_PREFETCH, else IDLE.
REQ-014 IDLE, i_core_cyc=1, no hit: valid cleared; go DEMAND, o_wb_adr={i_core_adr[31:2],2'b00}, o_wb_cyc=1 from the next cycle.
REQ-015 DEMAND, i_wb_ack=1: o_wb_cyc drops the next cycle; o_core_rdt takes i_wb_rdt and o_core_ack=1 in the next cycle; then PREFETCH at demand address+4 if WITH_PREFETCH, else IDLE.
REQ-016 PREFETCH, i_wb_ack=1, no matching core request: store i_wb_rdt with its tag, set valid, go IDLE.
REQ-017 PREFETCH with i_core_cyc=1 and address equal to the prefetch address: the returning word SHALL go directly to the core (ack in the cycle after i_wb_ack), is not stored, and the next PREFETCH (+4) starts.
REQ-018 PREFETCH with i_core_cyc=1 and a different address (jump): go DRAIN; the outstanding bus cycle SHALL complete and its data be discarded; then DEMAND at i_core_adr.
REQ-019 Prefetch address SHALL wrap modulo 2^32: 0xFFFFFFFC -> 0x00000000.
REQ-020 i_flush SHALL clear valid the next cycle; during PREFETCH it SHALL force DRAIN semantics (data discarded, not stored); i_flush with a same-cycle hit SHALL give a miss.
REQ-021 o_core_ack SHALL never be asserted in the cycle i_core_cyc first rises; it SHALL be at most one pulse per request and SHALL NOT assert while i_core_cyc=0.
REQ-022 o_wb_cyc SHALL stay asserted and o_wb_adr stable from issue until the cycle after i_wb_ack.
REQ-023 Hit latency SHALL be 1 cycle; miss latency SHALL be Wishbone latency + 1 cycle.

Reset
REQ-024 On i_rst_n=0, immediately: state IDLE, valid=0, o_wb_cyc=0, o_core_ack=0, o_wb_adr=0, o_core_rdt=0, tag=0.
REQ-025 Reset asserted mid bus cycle SHALL drop o_wb_cyc at once; a late i_wb_ack after reset SHALL be ignored.

Structure
REQ-026 No shared package; state encoding SHALL be local constants (2-bit).
REQ-027 SHALL be a single module with no sub-modules; buffer and FSM inline.

Verification
REQ-028 Cold miss: reset, request 0x00000100, wb ack after 3 cycles with 0x00000013 -> o_core_ack 1 cycle after i_wb_ack with rdt 0x00000013; prefetch issued at 0x00000104.
REQ-029 Sequential hit: after REQ-028, prefetch returns 0xDEADBEEF and completes; request 0x00000104 -> ack next cycle, rdt 0xDEADBEEF, no wb cycle for 0x104, prefetch at 0x00000108.
REQ-030 Jump during prefetch: prefetch to 0x108 outstanding, request 0x00000200 -> 0x108 data discarded, DEMAND at 0x00000200, core gets 0x200 data only.
REQ-031 Wrap: demand 0xFFFFFFFC -> prefetch o_wb_adr=0x00000000; later request 0x00000000 hits.
REQ-032 Flush: buffer valid for 0x104, pulse i_flush, request 0x104 -> miss, new wb cycle at 0x00000104.
REQ-033 Async reset mid-DEMAND: drop i_rst_n while o_wb_cyc=1 -> o_wb_cyc=0 with no clock edge, later i_wb_ack produces no o_core_ack.
